// File: rtl/restoring_div_param.sv
// Parametrised restoring divider: one quotient bit per clock behind a start/ready/valid handshake.
// Optional macro SIGNED_DIV_EN adds the signed_op port and truncating two's-complement division.
module restoring_div_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             signed_op,
`endif
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dbz_pend;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;
  logic             accept;
  logic             div_zero;

  assign accept   = start && ready;
  assign div_zero = (divisor == '0);

  // Partial remainder stays below the divisor, so only its low WIDTH bits are stored;
  // the trial subtraction is carried out at WIDTH+1 bits.
  assign r_shift = {r_acc, q_acc[WIDTH-1]};
  assign diff    = r_shift - {1'b0, dvsr};

`ifdef SIGNED_DIV_EN
  logic neg_a;
  logic neg_b;
  logic neg_q;
  logic neg_r;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign neg_a = signed_op && dividend[WIDTH-1];
  assign neg_b = signed_op && divisor[WIDTH-1];
  assign mag_a = cond_neg(dividend, neg_a);
  assign mag_b = cond_neg(divisor, neg_b);
  assign res_q = cond_neg(q_acc, neg_q);
  assign res_r = cond_neg(r_acc, neg_r);
`else
  assign mag_a = dividend;
  assign mag_b = divisor;
  assign res_q = q_acc;
  assign res_r = r_acc;
`endif

  // Control: state, handshake, iteration count and the published result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      valid    <= 1'b0;
      cnt      <= '0;
      dbz_pend <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      dbz      <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            valid <= 1'b1;
            quot  <= res_q;
            rem   <= res_r;
            dbz   <= dbz_pend;
          end
          if (start) begin
            cnt      <= '0;
            dbz_pend <= div_zero;
            state    <= div_zero ? DONE : CALC;
            ready    <= div_zero;
`ifdef SIGNED_DIV_EN
            // Divide-by-zero results are passed through raw, so no sign fix-up.
            neg_q    <= !div_zero && (neg_a ^ neg_b);
            neg_r    <= !div_zero && neg_a;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (cnt == LAST) begin
            state <= DONE;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Datapath: operand capture and one shift/trial-subtract/restore step per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (div_zero) begin
        q_acc <= '1;
        r_acc <= dividend;
      end else begin
        q_acc <= mag_a;
        r_acc <= '0;
        dvsr  <= mag_b;
      end
    end else if (state == CALC) begin
      if (!diff[WIDTH]) begin
        r_acc <= diff[WIDTH-1:0];
        q_acc <= {q_acc[WIDTH-2:0], 1'b1};
      end else begin
        r_acc <= r_shift[WIDTH-1:0];
        q_acc <= {q_acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
